// File: rtl/anim_pkg.sv
// Shared constants for the split/clean/paste animation path.
// The state encoding is also used by the memory address generator.
package anim_pkg;

    typedef logic [1:0] anim_state_t;

    localparam anim_state_t IDLE  = 2'b00;
    localparam anim_state_t SPLIT = 2'b01;
    localparam anim_state_t CLEAN = 2'b10;
    localparam anim_state_t PASTE = 2'b11;

    localparam int DEFAULT_MAX_OFFSET = 160;

endpackage

// File: rtl/anim_sequencer_if.sv
// Event inputs and animation status outputs between the front end,
// the sequencer and the address generator.
interface anim_sequencer_if #(
    parameter int OFS_W = 9
);
    logic             shift_pulse;
    logic             split_pulse;
    logic             vsync_start;
    logic [1:0]       state;
    logic [OFS_W-1:0] offset;
    logic             busy;
    logic             done;

    modport master (
        output shift_pulse, split_pulse, vsync_start,
        input  state, offset, busy, done
    );

    modport slave (
        input  shift_pulse, split_pulse, vsync_start,
        output state, offset, busy, done
    );
endinterface

// File: rtl/frame_tick_gen.sv
// Divides vsync_start pulses by FRAME_DIV to produce animation step ticks.
// clr restarts the count so every state gets a full FRAME_DIV vsyncs.
module frame_tick_gen #(
    parameter int FRAME_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic vsync_start,
    output logic tick
);
    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = vsync_start && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (vsync_start) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/anim_sequencer.sv
// Frame-synchronous split/clean/paste sequencer; offset only moves on vsync ticks.
//   state | meaning
//   IDLE  | waiting for shift/split request, offset held
//   SPLIT | opening (dir=0) or closing (dir=1) the split
//   CLEAN | opening towards MAX_OFFSET before the paste
//   PASTE | closing back to 0, then done
module anim_sequencer
    import anim_pkg::*;
#(
    parameter int FRAME_DIV  = 2,
    parameter int STEP       = 4,
    parameter int MAX_OFFSET = DEFAULT_MAX_OFFSET,
    parameter int OFS_W      = 9
) (
    input logic            clk,
    input logic            rst,
    anim_sequencer_if.slave bus
);
    localparam int W = OFS_W + 1;
    localparam logic [W-1:0]     MAX_W   = W'(MAX_OFFSET);
    localparam logic [W-1:0]     STEP_W  = W'(STEP);
    localparam logic [OFS_W-1:0] MAX_OFS = OFS_W'(MAX_OFFSET);

    anim_state_t      state_q, state_d;
    logic [OFS_W-1:0] offset_q, offset_d;
    logic             dir_q, dir_d;
    logic             done_q;
    logic             tick;
    logic             clr;

    logic [W-1:0]     ofs_ext, sum_w, diff_w;
    logic [OFS_W-1:0] inc_ofs, dec_ofs;

    frame_tick_gen #(
        .FRAME_DIV (FRAME_DIV)
    ) u_tick (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .vsync_start (bus.vsync_start),
        .tick        (tick)
    );

    // One extra bit keeps both directions from wrapping; diff_w MSB flags a borrow.
    assign ofs_ext = {1'b0, offset_q};
    assign sum_w   = ofs_ext + STEP_W;
    assign diff_w  = ofs_ext - STEP_W;
    assign inc_ofs = (sum_w > MAX_W) ? MAX_OFS : sum_w[OFS_W-1:0];
    assign dec_ofs = diff_w[W-1] ? '0 : diff_w[OFS_W-1:0];

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        dir_d    = dir_q;
        case (state_q)
            IDLE: begin
                if (bus.shift_pulse) begin
                    state_d = CLEAN;
                end else if (bus.split_pulse) begin
                    state_d = SPLIT;
                    dir_d   = (offset_q == MAX_OFS);
                end
            end
            SPLIT: begin
                if (tick) begin
                    if (!dir_q) begin
                        offset_d = inc_ofs;
                        if (inc_ofs == MAX_OFS) state_d = IDLE;
                    end else begin
                        offset_d = dec_ofs;
                        if (dec_ofs == '0) state_d = IDLE;
                    end
                end
            end
            CLEAN: begin
                if (tick) begin
                    offset_d = inc_ofs;
                    if (inc_ofs == MAX_OFS) state_d = PASTE;
                end
            end
            PASTE: begin
                if (tick) begin
                    offset_d = dec_ofs;
                    if (dec_ofs == '0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Any state change restarts the frame count.
    assign clr = (state_d != state_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            offset_q <= '0;
            dir_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            dir_q    <= dir_d;
            done_q   <= (state_d == IDLE) && (state_q != IDLE);
        end
    end

    assign bus.state  = state_q;
    assign bus.offset = offset_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
endmodule

// File: tb/tb_anim_sequencer.sv
// Self-checking bench for anim_sequencer: main instance (FRAME_DIV=2, STEP=40)
// and a saturation instance (FRAME_DIV=1, STEP=50), both MAX_OFFSET=160.
module tb_anim_sequencer;
    import anim_pkg::*;

    typedef struct packed {
        logic [1:0] st;
        logic [8:0] ofs;
        logic       dn;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    anim_sequencer_if #(.OFS_W(9)) bus_a ();
    anim_sequencer_if #(.OFS_W(9)) bus_b ();

    anim_sequencer #(
        .FRAME_DIV(2), .STEP(40), .MAX_OFFSET(160), .OFS_W(9)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave)
    );

    anim_sequencer #(
        .FRAME_DIV(1), .STEP(50), .MAX_OFFSET(160), .OFS_W(9)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic vsync_a();
        bus_a.vsync_start = 1'b1;
        step();
        bus_a.vsync_start = 1'b0;
    endtask

    task automatic vsync_b();
        bus_b.vsync_start = 1'b1;
        step();
        bus_b.vsync_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (bus_a.state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d want %0d", bus_a.state, IDLE);
        end
        checks++;
        if (bus_a.offset !== 9'd0) begin
            errors++;
            $display("FAIL reset_offset: got %0d want 0", bus_a.offset);
        end
        checks++;
        if (bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", bus_a.busy);
        end
        checks++;
        if (bus_a.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b want 0", bus_a.done);
        end
    endtask

    task automatic test_split_open_close();
        exp_t e;
        for (int pass = 0; pass < 2; pass++) begin
            bus_a.split_pulse = 1'b1;
            step();
            bus_a.split_pulse = 1'b0;
            checks++;
            if (bus_a.state !== SPLIT || bus_a.busy !== 1'b1) begin
                errors++;
                $display("FAIL split_enter pass %0d: got st=%0d busy=%b want st=%0d busy=1",
                         pass, bus_a.state, bus_a.busy, SPLIT);
            end
            for (int i = 1; i <= 8; i++) begin
                e.ofs = (pass == 0) ? 9'((i / 2) * 40) : 9'(160 - (i / 2) * 40);
                e.st  = (i == 8) ? IDLE : SPLIT;
                e.dn  = (i == 8);
                sb.push_back(e);
                vsync_a();
                e = sb.pop_front();
                checks++;
                if ({bus_a.state, bus_a.offset, bus_a.done} !== e) begin
                    errors++;
                    $display("FAIL split pass %0d vsync %0d: got st=%0d ofs=%0d done=%b want st=%0d ofs=%0d done=%b",
                             pass, i, bus_a.state, bus_a.offset, bus_a.done, e.st, e.ofs, e.dn);
                end
                step();
                checks++;
                if ({bus_a.state, bus_a.offset, bus_a.done} !== {e.st, e.ofs, 1'b0}) begin
                    errors++;
                    $display("FAIL split_gap pass %0d vsync %0d: got st=%0d ofs=%0d done=%b want st=%0d ofs=%0d done=0",
                             pass, i, bus_a.state, bus_a.offset, bus_a.done, e.st, e.ofs);
                end
            end
            vsync_a();
            checks++;
            if (bus_a.offset !== ((pass == 0) ? 9'd160 : 9'd0) || bus_a.state !== IDLE) begin
                errors++;
                $display("FAIL idle_vsync pass %0d: got st=%0d ofs=%0d want st=0 ofs=%0d",
                         pass, bus_a.state, bus_a.offset, (pass == 0) ? 160 : 0);
            end
        end
    endtask

    // with_noise drives both pulses during several gap cycles; they must be ignored.
    task automatic test_clean_paste(input bit with_noise);
        exp_t e;
        bus_a.shift_pulse = 1'b1;
        bus_a.split_pulse = with_noise;
        step();
        bus_a.shift_pulse = 1'b0;
        bus_a.split_pulse = 1'b0;
        checks++;
        if (bus_a.state !== CLEAN) begin
            errors++;
            $display("FAIL clean_enter noise=%0d: got st=%0d want st=%0d", with_noise, bus_a.state, CLEAN);
        end
        for (int i = 1; i <= 16; i++) begin
            e.ofs = (i <= 8) ? 9'((i / 2) * 40) : 9'(160 - ((i - 8) / 2) * 40);
            e.st  = (i < 8) ? CLEAN : ((i < 16) ? PASTE : IDLE);
            e.dn  = (i == 16);
            sb.push_back(e);
            vsync_a();
            e = sb.pop_front();
            checks++;
            if ({bus_a.state, bus_a.offset, bus_a.done} !== e) begin
                errors++;
                $display("FAIL clean_paste noise=%0d vsync %0d: got st=%0d ofs=%0d done=%b want st=%0d ofs=%0d done=%b",
                         with_noise, i, bus_a.state, bus_a.offset, bus_a.done, e.st, e.ofs, e.dn);
            end
            if (with_noise && (i % 2 == 1) && i < 15) begin
                bus_a.shift_pulse = 1'b1;
                bus_a.split_pulse = 1'b1;
            end
            step();
            bus_a.shift_pulse = 1'b0;
            bus_a.split_pulse = 1'b0;
            checks++;
            if ({bus_a.state, bus_a.offset, bus_a.done} !== {e.st, e.ofs, 1'b0}) begin
                errors++;
                $display("FAIL clean_paste_gap noise=%0d vsync %0d: got st=%0d ofs=%0d done=%b want st=%0d ofs=%0d done=0",
                         with_noise, i, bus_a.state, bus_a.offset, bus_a.done, e.st, e.ofs);
            end
        end
        step();
        checks++;
        if (bus_a.state !== IDLE || bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL no_queue noise=%0d: got st=%0d busy=%b want st=0 busy=0",
                     with_noise, bus_a.state, bus_a.busy);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        for (int pass = 0; pass < 2; pass++) begin
            bus_b.split_pulse = 1'b1;
            step();
            bus_b.split_pulse = 1'b0;
            for (int i = 1; i <= 4; i++) begin
                if (pass == 0) e.ofs = (i < 4) ? 9'(50 * i) : 9'd160;
                else           e.ofs = (i < 4) ? 9'(160 - 50 * i) : 9'd0;
                e.st = (i == 4) ? IDLE : SPLIT;
                e.dn = (i == 4);
                sb.push_back(e);
                vsync_b();
                e = sb.pop_front();
                checks++;
                if ({bus_b.state, bus_b.offset, bus_b.done} !== e) begin
                    errors++;
                    $display("FAIL saturation pass %0d vsync %0d: got st=%0d ofs=%0d done=%b want st=%0d ofs=%0d done=%b",
                             pass, i, bus_b.state, bus_b.offset, bus_b.done, e.st, e.ofs, e.dn);
                end
            end
            vsync_b();
            checks++;
            if (bus_b.offset !== ((pass == 0) ? 9'd160 : 9'd0) || bus_b.done !== 1'b0) begin
                errors++;
                $display("FAIL saturation_hold pass %0d: got ofs=%0d done=%b want ofs=%0d done=0",
                         pass, bus_b.offset, bus_b.done, (pass == 0) ? 160 : 0);
            end
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        bus_a.shift_pulse = 1'b1;
        step();
        bus_a.shift_pulse = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            e.ofs = (i <= 8) ? 9'((i / 2) * 40) : 9'(160 - ((i - 8) / 2) * 40);
            e.st  = (i < 8) ? CLEAN : PASTE;
            e.dn  = 1'b0;
            sb.push_back(e);
            vsync_a();
            e = sb.pop_front();
            checks++;
            if ({bus_a.state, bus_a.offset, bus_a.done} !== e) begin
                errors++;
                $display("FAIL mid_reset_run vsync %0d: got st=%0d ofs=%0d done=%b want st=%0d ofs=%0d done=%b",
                         i, bus_a.state, bus_a.offset, bus_a.done, e.st, e.ofs, e.dn);
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({bus_a.state, bus_a.offset, bus_a.done, bus_a.busy} !== {IDLE, 9'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got st=%0d ofs=%0d done=%b busy=%b want st=0 ofs=0 done=0 busy=0",
                     bus_a.state, bus_a.offset, bus_a.done, bus_a.busy);
        end
        step();
        checks++;
        if (bus_a.done !== 1'b0 || bus_a.state !== IDLE) begin
            errors++;
            $display("FAIL mid_reset_no_done: got st=%0d done=%b want st=0 done=0", bus_a.state, bus_a.done);
        end
        bus_a.shift_pulse = 1'b1;
        step();
        bus_a.shift_pulse = 1'b0;
        vsync_a();
        checks++;
        if (bus_a.offset !== 9'd0) begin
            errors++;
            $display("FAIL post_reset_first_vsync: got ofs=%0d want 0", bus_a.offset);
        end
        vsync_a();
        checks++;
        if (bus_a.offset !== 9'd40 || bus_a.state !== CLEAN) begin
            errors++;
            $display("FAIL post_reset_tick: got st=%0d ofs=%0d want st=%0d ofs=40",
                     bus_a.state, bus_a.offset, CLEAN);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_a.shift_pulse = 1'b0;
        bus_a.split_pulse = 1'b0;
        bus_a.vsync_start = 1'b0;
        bus_b.shift_pulse = 1'b0;
        bus_b.split_pulse = 1'b0;
        bus_b.vsync_start = 1'b0;
        test_reset();
        test_split_open_close();
        test_clean_paste(1'b0);
        test_clean_paste(1'b1);
        test_saturation();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
